// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, FSM states and operand record for the ALU arbiter slice.
package alu_arbiter_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] OP_ADD = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] OP_SUB = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] OP_AND = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] OP_OR  = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] OP_XOR = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] OP_NOT = 4'd5;
    localparam logic [ALU_CTRL_W-1:0] OP_INC = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] OP_SLL = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] OP_SRL = 4'd8;
    localparam logic [ALU_CTRL_W-1:0] OP_SRA = 4'd9;
    localparam logic [ALU_CTRL_W-1:0] OP_ROL = 4'd10;
    localparam logic [ALU_CTRL_W-1:0] OP_ROR = 4'd11;
    localparam logic [ALU_CTRL_W-1:0] OP_EQ  = 4'd12;
    localparam logic [ALU_CTRL_W-1:0] OP_NOP = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] ctrl;
        logic [ALU_DATA_W-1:0] x;
        logic [ALU_DATA_W-1:0] y;
    } alu_op_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: rr_ptr breaks ties, a lone requester always wins.
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic       grant,
    output logic [1:0] grant_oh
);

    // Pick the winner and qualify the one-hot with its valid bit
    always_comb begin
        grant    = (valid == 2'b11) ? rr_ptr : valid[1];
        grant_oh = valid[grant] ? onehot2(grant) : 2'b00;
    end

endmodule

// File: rtl/alu_rtl.sv
// Combinational 8-bit ALU. Shifts by amount move y by x[2:0]; single-bit
// shifts/rotates act on x. Carry is only meaningful for add/sub/inc.
module alu_rtl
    import alu_arbiter_pkg::*;
(
    input  logic [ALU_CTRL_W-1:0] ctrl,
    input  logic [ALU_DATA_W-1:0] x,
    input  logic [ALU_DATA_W-1:0] y,
    output logic [ALU_DATA_W-1:0] out,
    output logic                  carry
);

    // Decode opcode; unlisted codes (13..15) produce zero
    always_comb begin
        out   = '0;
        carry = 1'b0;
        case (ctrl)
            OP_ADD: {carry, out} = {1'b0, x} + {1'b0, y};
            OP_SUB: {carry, out} = {1'b0, x} - {1'b0, y};
            OP_AND: out = x & y;
            OP_OR:  out = x | y;
            OP_XOR: out = x ^ y;
            OP_NOT: out = ~x;
            OP_INC: {carry, out} = {1'b0, x} + 9'd1;
            OP_SLL: out = y << x[2:0];
            OP_SRL: out = y >> x[2:0];
            OP_SRA: out = {x[7], x[7:1]};
            OP_ROL: out = {x[6:0], x[7]};
            OP_ROR: out = {x[0], x[7:1]};
            OP_EQ:  out = {7'd0, x == y};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters. Each op walks
// IDLE -> EXEC -> RESP so the ALU inputs sit on registers for a full cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [CTRL_W-1:0] req_ctrl0,
    input  logic [CTRL_W-1:0] req_ctrl1,
    input  logic [DATA_W-1:0] req_x0,
    input  logic [DATA_W-1:0] req_x1,
    input  logic [DATA_W-1:0] req_y0,
    input  logic [DATA_W-1:0] req_y1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_out,
    output logic              rsp_carry,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              owner_q, owner_d;
    alu_op_t           op_q, op_d;
    logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              grant;
    logic [1:0]        grant_oh;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic              accept;
    logic              rsp_done;

    rr_arb2 u_arb (
        .valid    (req_valid),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .grant_oh (grant_oh)
    );

    // ALU sees only registered operands, never the live request buses
    alu_rtl u_alu (
        .ctrl  (op_q.ctrl),
        .x     (op_q.x),
        .y     (op_q.y),
        .out   (alu_out),
        .carry (alu_carry)
    );

    // grant_oh is already qualified by req_valid[grant]
    assign accept   = (state_q == S_IDLE) && (grant_oh != 2'b00);
    assign rsp_done = (state_q == S_RESP) && rsp_ready[owner_q];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: one cycle per phase, RESP waits for the owner's ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: requests are only accepted from IDLE
    always_comb begin
        req_ready = (state_q == S_IDLE) ? grant_oh : 2'b00;
        busy      = (state_q == S_EXEC) || (state_q == S_RESP);
    end

    // Datapath next values: capture on accept, latch result in EXEC, retire on handshake
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        rsp_out_d   = rsp_out_q;
        rsp_carry_d = rsp_carry_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        if (accept) begin
            owner_d = grant;
            op_d.ctrl = grant ? req_ctrl1 : req_ctrl0;
            op_d.x    = grant ? req_x1    : req_x0;
            op_d.y    = grant ? req_y1    : req_y0;
        end
        if (state_q == S_EXEC) begin
            rsp_out_d   = alu_out;
            rsp_carry_d = alu_carry;
            rsp_valid_d = onehot2(owner_q);
        end
        if (rsp_done) begin
            rsp_valid_d = 2'b00;
            rr_ptr_d    = ~owner_q;
            op_count_d  = op_count_q + 1'b1;
        end
    end

    // Datapath registers; reset drops any in-flight op without a response
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            op_q        <= '0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_valid_q <= 2'b00;
            op_count_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            rsp_out_q   <= rsp_out_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_carry = rsp_carry_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// then random traffic against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [3:0]       req_ctrl0 = 4'd0, req_ctrl1 = 4'd0;
    logic [7:0]       req_x0 = 8'd0, req_x1 = 8'd0, req_y0 = 8'd0, req_y1 = 8'd0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = 2'b00;
    logic [7:0]       rsp_out;
    logic             rsp_carry;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    alu_arbiter #(.DATA_W(8), .CTRL_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_carry(rsp_carry),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    typedef struct {
        bit         rst;
        logic [1:0] valid;
        logic [3:0] c0; logic [7:0] x0; logic [7:0] y0;
        logic [3:0] c1; logic [7:0] x1; logic [7:0] y1;
        bit         gnt;
        logic [7:0] eout;
        bit         ecar;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh(input bit i);
        return i ? 2'b10 : 2'b01;
    endfunction

    // Reference ALU in plain integer arithmetic
    function automatic void alu_ref(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                                    output logic [7:0] o, output logic cy);
        int a, b, r;
        a = int'(x); b = int'(y); r = 0; cy = 1'b0;
        case (c)
            4'd0:  begin r = a + b; cy = (r > 255); end
            4'd1:  begin r = a - b; cy = (r < 0); if (r < 0) r += 256; end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = 255 - a;
            4'd6:  begin r = a + 1; cy = (r > 255); end
            4'd7:  r = b * (1 << (a % 8));
            4'd8:  r = b / (1 << (a % 8));
            4'd9:  r = a / 2 + ((a >= 128) ? 128 : 0);
            4'd10: r = a * 2 + a / 128;
            4'd11: r = a / 2 + (a % 2) * 128;
            4'd12: r = (a == b) ? 1 : 0;
            default: r = 0;
        endcase
        o = 8'(r % 256);
    endfunction

    task automatic do_reset();
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
    endtask

    // One full op: accept, EXEC, RESP, handshake; the loser stays valid throughout
    task automatic run_op(input vec_t v);
        if (v.rst) do_reset();
        req_ctrl0 = v.c0; req_x0 = v.x0; req_y0 = v.y0;
        req_ctrl1 = v.c1; req_x1 = v.x1; req_y1 = v.y1;
        req_valid = v.valid; rsp_ready = 2'b00;
        #1;
        chk("op_req_ready_idle", 32'(req_ready), 32'(oh(v.gnt)));
        tick();
        req_valid = v.valid & ~oh(v.gnt);
        #1;
        chk("op_busy_exec", 32'(busy), 32'd1);
        chk("op_req_ready_exec", 32'(req_ready), 32'd0);
        chk("op_rsp_valid_exec", 32'(rsp_valid), 32'd0);
        tick();
        chk("op_rsp_valid", 32'(rsp_valid), 32'(oh(v.gnt)));
        chk("op_rsp_out", 32'(rsp_out), 32'(v.eout));
        chk("op_rsp_carry", 32'(rsp_carry), 32'(v.ecar));
        chk("op_req_ready_resp", 32'(req_ready), 32'd0);
        rsp_ready = oh(v.gnt);
        tick();
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
        chk("op_rsp_valid_done", 32'(rsp_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("op_busy_done", 32'(busy), 32'd0);
        req_valid = 2'b00; rsp_ready = 2'b00;
    endtask

    initial begin
        logic [1:0] grants[$];
        vec_t nopv;
        // Random-phase model state
        bit         m_inflight, m_owner, m_pri, m_acc, m_done, m_g;
        int         m_age;
        logic [7:0] m_out;
        logic       m_car;
        logic [1:0] e_rr, e_rv;

        //         rst  valid  c0     x0      y0      c1     x1      y1     gnt  out     car
        vecs[0] = '{1, 2'b01, 4'd0,  8'd3,   8'd10,  4'd0,  8'd0,   8'd0,  0, 8'd13,  0};
        vecs[1] = '{1, 2'b11, 4'd8,  8'd4,   8'hB3,  4'd12, 8'hB3,  8'hB3, 0, 8'h0B,  0};
        vecs[2] = '{0, 2'b11, 4'd8,  8'd4,   8'hB3,  4'd12, 8'hB3,  8'hB3, 1, 8'h01,  0};
        vecs[3] = '{1, 2'b10, 4'd0,  8'd0,   8'd0,   4'd9,  8'hB3,  8'h01, 1, 8'hD9,  0};
        vecs[4] = '{0, 2'b11, 4'd1,  8'd5,   8'd7,   4'd0,  8'd1,   8'd1,  0, 8'hFE,  1};
        vecs[5] = '{0, 2'b01, 4'd2,  8'hF0, 8'h3C,  4'd0,  8'd0,   8'd0,  0, 8'h30,  0};
        vecs[6] = '{0, 2'b10, 4'd0,  8'd0,   8'd0,   4'd0,  8'hFF,  8'h02, 1, 8'h01,  1};
        vecs[7] = '{0, 2'b01, 4'd10, 8'h81, 8'h00,  4'd0,  8'd0,   8'd0,  0, 8'h03,  0};
        vecs[8] = '{0, 2'b10, 4'd0,  8'd0,   8'd0,   4'd7,  8'd3,   8'hF3, 1, 8'h98,  0};

        tick(); tick();
        do_reset();

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // Saturation: both always valid, ready always high
        do_reset();
        req_ctrl0 = 4'd0; req_x0 = 8'd1; req_y0 = 8'd1;
        req_ctrl1 = 4'd0; req_x1 = 8'd2; req_y1 = 8'd2;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (rsp_valid != 2'b00) grants.push_back(rsp_valid);
            tick();
        end
        exp_cnt = 4;
        chk("sat_op_count", 32'(op_count), 32'd4);
        chk("sat_num_rsp", 32'(grants.size()), 32'd4);
        for (int k = 0; k < grants.size() && k < 4; k++)
            chk("sat_grant_order", 32'(grants[k]), 32'(oh(k[0])));
        req_valid = 2'b00; rsp_ready = 2'b00;

        // Backpressure on requester 1's SRA result
        do_reset();
        req_ctrl1 = 4'd9; req_x1 = 8'hB3; req_y1 = 8'h01;
        req_ctrl0 = 4'd0; req_x0 = 8'd1; req_y0 = 8'd1;
        req_valid = 2'b10;
        #1;
        chk("bp_req_ready_idle", 32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b11;
        tick();
        rsp_ready = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rsp_valid_held", 32'(rsp_valid), 32'b10);
            chk("bp_rsp_out_held", 32'(rsp_out), 32'hD9);
            chk("bp_req_ready_blocked", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        chk("bp_no_comb_path", 32'(req_ready), 32'd0);
        tick();
        exp_cnt = 1;
        chk("bp_rsp_valid_done", 32'(rsp_valid), 32'd0);
        chk("bp_op_count", 32'(op_count), 32'd1);
        chk("bp_next_grant", 32'(req_ready), 32'b01);
        req_valid = 2'b00; rsp_ready = 2'b00;

        // Reset while in EXEC discards the op
        do_reset();
        req_ctrl0 = 4'd7; req_x0 = 8'd3; req_y0 = 8'hF3;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        #1;
        chk("rx_busy_exec", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rx_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rx_busy", 32'(busy), 32'd0);
        chk("rx_op_count", 32'(op_count), 32'd0);
        tick();
        chk("rx_no_late_rsp", 32'(rsp_valid), 32'd0);
        chk("rx_busy_after", 32'(busy), 32'd0);
        req_valid = 2'b01;
        #1;
        chk("rx_idle_ready", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        exp_cnt = 0;

        // Nop ops and counter wrap (CNT_W = 4)
        do_reset();
        nopv = '{0, 2'b01, 4'd14, 8'hB3, 8'hAF, 4'd0, 8'd0, 8'd0, 0, 8'd0, 0};
        for (int n = 0; n < 16; n++) run_op(nopv);
        chk("wrap_op_count", 32'(op_count), 32'd0);

        // Random traffic vs transaction-level model
        do_reset();
        m_inflight = 0; m_owner = 0; m_pri = 0; m_age = 0; m_out = 8'd0; m_car = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!req_valid[0] && $urandom_range(0, 1) == 1) begin
                req_valid[0] = 1'b1;
                req_ctrl0 = 4'($urandom_range(0, 15)); req_x0 = 8'($urandom); req_y0 = 8'($urandom);
            end
            if (!req_valid[1] && $urandom_range(0, 1) == 1) begin
                req_valid[1] = 1'b1;
                req_ctrl1 = 4'($urandom_range(0, 15)); req_x1 = 8'($urandom); req_y1 = 8'($urandom);
            end
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            m_g = (req_valid == 2'b11) ? m_pri : req_valid[1];
            e_rr = (!m_inflight && req_valid != 2'b00) ? oh(m_g) : 2'b00;
            e_rv = (m_inflight && m_age >= 1) ? oh(m_owner) : 2'b00;
            chk("rnd_req_ready", 32'(req_ready), 32'(e_rr));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rnd_busy", 32'(busy), 32'(m_inflight));
            chk("rnd_op_count", 32'(op_count), 32'(exp_cnt));
            if (e_rv != 2'b00) begin
                chk("rnd_rsp_out", 32'(rsp_out), 32'(m_out));
                chk("rnd_rsp_carry", 32'(rsp_carry), 32'(m_car));
            end
            m_acc  = (e_rr != 2'b00);
            m_done = (e_rv != 2'b00) && rsp_ready[m_owner];
            if (m_acc) begin
                if (m_g) alu_ref(req_ctrl1, req_x1, req_y1, m_out, m_car);
                else     alu_ref(req_ctrl0, req_x0, req_y0, m_out, m_car);
            end
            tick();
            if (m_done) begin
                m_inflight = 0;
                exp_cnt = (exp_cnt + 1) % CNT_MOD;
                m_pri = ~m_owner;
            end else if (m_acc) begin
                m_inflight = 1; m_owner = m_g; m_age = 0;
                req_valid[m_g] = 1'b0;
            end else if (m_inflight) begin
                m_age++;
            end
        end
        req_valid = 2'b00; rsp_ready = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
